// File: rtl/urv_dm_wb_master.sv
// Data-memory responder for the uRV pipeline: one load/store request becomes
// one Wishbone-pipelined transfer, with a response timeout and error signalling.
module urv_dm_wb_master #(
    parameter int unsigned g_timeout  = 256,
    parameter logic [31:0] g_err_data = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_busy_o,
    output logic        dm_bus_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    localparam int unsigned CW = $clog2(g_timeout);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic           r_we;
    logic           r_err;
    logic [31:0]    r_adr;
    logic [3:0]     r_sel;
    logic [31:0]    r_dat;
    logic [31:0]    r_data_l;
    logic           w_req;
    logic           w_tmo;
    logic           w_fin_err;
    logic           w_unused;

    assign w_req    = dm_load_i | dm_store_i;
    assign w_tmo    = (r_cnt == CW'(g_timeout - 1));
    // Byte offset never reaches the bus; the writeback stage extracts lanes.
    assign w_unused = ^dm_addr_i[1:0];

    always_comb begin
        w_next    = r_state;
        w_fin_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                // A response is only meaningful once the strobe has been accepted.
                if (w_tmo) begin
                    w_next    = S_DONE;
                    w_fin_err = 1'b1;
                end else if (!wb_stall_i) begin
                    w_next    = (wb_ack_i | wb_err_i) ? S_DONE : S_WAIT;
                    w_fin_err = wb_err_i;
                end
            end
            S_WAIT: begin
                if (wb_ack_i | wb_err_i | w_tmo) begin
                    w_next    = S_DONE;
                    w_fin_err = wb_err_i | w_tmo;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_adr    <= '0;
            r_sel    <= '0;
            r_dat    <= '0;
            r_data_l <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_we  <= dm_store_i & ~dm_load_i;
                        r_adr <= {dm_addr_i[31:2], 2'b00};
                        r_sel <= dm_load_i ? 4'hF : dm_data_select_i;
                        r_dat <= dm_data_s_i;
                        r_cnt <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_next == S_DONE) begin
                        r_err <= w_fin_err;
                        if (!r_we) r_data_l <= w_fin_err ? g_err_data : wb_dat_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wb_cyc_o        = (r_state == S_ISSUE) | (r_state == S_WAIT);
    assign wb_stb_o        = (r_state == S_ISSUE);
    assign wb_we_o         = r_we;
    assign wb_adr_o        = r_adr;
    assign wb_sel_o        = r_sel;
    assign wb_dat_o        = r_dat;
    assign dm_data_l_o     = r_data_l;
    assign dm_busy_o       = (r_state != S_IDLE);
    assign dm_load_done_o  = (r_state == S_DONE) & ~r_we;
    assign dm_store_done_o = (r_state == S_DONE) & r_we;
    assign dm_bus_err_o    = (r_state == S_DONE) & r_err;

endmodule

// File: tb/tb_urv_dm_wb_master.sv
// Directed bench for urv_dm_wb_master; inputs driven and outputs checked on negedge.
module tb_urv_dm_wb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_s;
    logic [3:0]  dm_sel;
    logic        dm_load;
    logic        dm_store;
    logic [31:0] dm_data_l;
    logic        ld_done;
    logic        st_done;
    logic        busy;
    logic        bus_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;

    int tests = 0;
    int fails = 0;

    // {cyc, stb, busy, load_done, store_done, bus_err}
    logic [5:0] st;
    assign st = {wb_cyc, wb_stb, busy, ld_done, st_done, bus_err};

    always #5 clk = ~clk;

    urv_dm_wb_master #(
        .g_timeout (8),
        .g_err_data(32'hDEADBEEF)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .dm_addr_i       (dm_addr),
        .dm_data_s_i     (dm_data_s),
        .dm_data_select_i(dm_sel),
        .dm_load_i       (dm_load),
        .dm_store_i      (dm_store),
        .dm_data_l_o     (dm_data_l),
        .dm_load_done_o  (ld_done),
        .dm_store_done_o (st_done),
        .dm_busy_o       (busy),
        .dm_bus_err_o    (bus_err),
        .wb_cyc_o        (wb_cyc),
        .wb_stb_o        (wb_stb),
        .wb_we_o         (wb_we),
        .wb_adr_o        (wb_adr),
        .wb_sel_o        (wb_sel),
        .wb_dat_o        (wb_dat_o),
        .wb_dat_i        (wb_dat_i),
        .wb_ack_i        (wb_ack),
        .wb_err_i        (wb_err),
        .wb_stall_i      (wb_stall)
    );

    task automatic test_reset();
        rst = 1'b1; dm_addr = '0; dm_data_s = '0; dm_sel = '0;
        dm_load = 1'b0; dm_store = 1'b0; wb_dat_i = '0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (st !== 6'b000000) begin
            fails++; $display("FAIL reset_status got=%b exp=%b", st, 6'b000000);
        end
        tests++;
        if ({wb_we, wb_sel, wb_adr, wb_dat_o, dm_data_l} !== 101'd0) begin
            fails++;
            $display("FAIL reset_regs got we=%b sel=%h adr=%h dat=%h dl=%h exp all 0",
                     wb_we, wb_sel, wb_adr, wb_dat_o, dm_data_l);
        end
        rst = 1'b0;
    endtask

    task automatic test_load(input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] exp_adr;
        exp_adr = {addr[31:2], 2'b00};
        @(negedge clk); dm_addr = addr; dm_load = 1'b1;           // N
        @(negedge clk); dm_load = 1'b0;                           // N+1
        tests++;
        if ({st, wb_we, wb_sel} !== {6'b111000, 1'b0, 4'hF}) begin
            fails++; $display("FAIL load_issue got st=%b we=%b sel=%h exp st=111000 we=0 sel=f",
                              st, wb_we, wb_sel);
        end
        tests++;
        if (wb_adr !== exp_adr) begin
            fails++; $display("FAIL load_adr got=%h exp=%h", wb_adr, exp_adr);
        end
        @(negedge clk); wb_ack = 1'b1; wb_dat_i = rdata;          // N+2
        tests++;
        if (st !== 6'b101000) begin
            fails++; $display("FAIL load_wait got=%b exp=101000", st);
        end
        @(negedge clk); wb_ack = 1'b0; wb_dat_i = '0;             // N+3
        tests++;
        if (st !== 6'b001100 || dm_data_l !== rdata) begin
            fails++; $display("FAIL load_done got st=%b dl=%h exp st=001100 dl=%h",
                              st, dm_data_l, rdata);
        end
        @(negedge clk);                                           // N+4
        tests++;
        if (st !== 6'b000000) begin
            fails++; $display("FAIL load_idle got=%b exp=000000", st);
        end
    endtask

    task automatic test_store();
        @(negedge clk); dm_addr = 32'h201; dm_data_s = 32'h0000AB00;
        dm_sel = 4'b0010; dm_store = 1'b1;                        // N
        @(negedge clk); dm_store = 1'b0;                          // N+1
        tests++;
        if ({st, wb_we, wb_sel, wb_adr, wb_dat_o} !==
            {6'b111000, 1'b1, 4'b0010, 32'h200, 32'h0000AB00}) begin
            fails++; $display("FAIL store_issue got st=%b we=%b sel=%b adr=%h dat=%h exp 111000 1 0010 200 0000ab00",
                              st, wb_we, wb_sel, wb_adr, wb_dat_o);
        end
        @(negedge clk); wb_ack = 1'b1;                            // N+2
        @(negedge clk); wb_ack = 1'b0;                            // N+3
        tests++;
        if (st !== 6'b001010 || dm_data_l !== 32'h11223344) begin
            fails++; $display("FAIL store_done got st=%b dl=%h exp st=001010 dl=11223344",
                              st, dm_data_l);
        end
        @(negedge clk);                                           // N+4
        tests++;
        if (st !== 6'b000000) begin
            fails++; $display("FAIL store_single_pulse got=%b exp=000000", st);
        end
    endtask

    task automatic test_stall();
        @(negedge clk); dm_addr = 32'h300; dm_load = 1'b1; wb_stall = 1'b1;  // N
        for (int i = 1; i <= 4; i++) begin                        // N+1..N+4
            @(negedge clk); dm_load = 1'b0;
            if (i == 4) wb_stall = 1'b0;
            tests++;
            if (st !== 6'b111000 || wb_adr !== 32'h300) begin
                fails++; $display("FAIL stall_hold cyc%0d got st=%b adr=%h exp st=111000 adr=300",
                                  i, st, wb_adr);
            end
        end
        @(negedge clk); wb_ack = 1'b1; wb_dat_i = 32'hCAFEF00D;  // N+5
        tests++;
        if (st !== 6'b101000) begin
            fails++; $display("FAIL stall_wait got=%b exp=101000", st);
        end
        @(negedge clk); wb_ack = 1'b0; wb_dat_i = '0;             // N+6
        tests++;
        if (st !== 6'b001100 || dm_data_l !== 32'hCAFEF00D) begin
            fails++; $display("FAIL stall_done got st=%b dl=%h exp st=001100 dl=cafef00d",
                              st, dm_data_l);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk); dm_addr = 32'h40; dm_load = 1'b1;         // N
        for (int k = 1; k <= 8; k++) begin                        // N+1..N+8
            @(negedge clk); dm_load = 1'b0;
            tests++;
            if (st[5] !== 1'b1 || st[3:0] !== 4'b1000) begin
                fails++; $display("FAIL timeout_pending cyc%0d got=%b exp cyc=1 busy=1 no done", k, st);
            end
        end
        @(negedge clk);                                           // N+9
        tests++;
        if (st !== 6'b001101 || dm_data_l !== 32'hDEADBEEF) begin
            fails++; $display("FAIL timeout_done got st=%b dl=%h exp st=001101 dl=deadbeef",
                              st, dm_data_l);
        end
        @(negedge clk); wb_ack = 1'b1; wb_dat_i = 32'h12345678;  // N+10 late ack
        @(negedge clk); wb_ack = 1'b0; wb_dat_i = '0;             // N+11
        tests++;
        if (st !== 6'b000000 || dm_data_l !== 32'hDEADBEEF) begin
            fails++; $display("FAIL timeout_late_ack got st=%b dl=%h exp st=000000 dl=deadbeef",
                              st, dm_data_l);
        end
    endtask

    task automatic test_store_err();
        @(negedge clk); dm_addr = 32'h80; dm_data_s = 32'hA5A50000;
        dm_sel = 4'b1100; dm_store = 1'b1;                        // N
        @(negedge clk); dm_store = 1'b0;                          // N+1
        tests++;
        if (wb_we !== 1'b1 || wb_sel !== 4'b1100) begin
            fails++; $display("FAIL err_store_issue got we=%b sel=%b exp we=1 sel=1100", wb_we, wb_sel);
        end
        @(negedge clk); wb_err = 1'b1;                            // N+2
        @(negedge clk); wb_err = 1'b0;                            // N+3
        tests++;
        if (st !== 6'b001011 || dm_data_l !== 32'hDEADBEEF) begin
            fails++; $display("FAIL err_store_done got st=%b dl=%h exp st=001011 dl=deadbeef",
                              st, dm_data_l);
        end
        @(negedge clk);                                           // N+4
        tests++;
        if (st !== 6'b000000) begin
            fails++; $display("FAIL err_store_idle got=%b exp=000000", st);
        end
    endtask

    task automatic test_collision_reset();
        @(negedge clk); dm_addr = 32'h500; dm_sel = 4'b0011;
        dm_load = 1'b1; dm_store = 1'b1;                          // N
        @(negedge clk); dm_load = 1'b0; dm_store = 1'b0;          // N+1
        tests++;
        if ({st, wb_we, wb_sel} !== {6'b111000, 1'b0, 4'hF}) begin
            fails++; $display("FAIL collision_load_wins got st=%b we=%b sel=%h exp 111000 0 f",
                              st, wb_we, wb_sel);
        end
        @(negedge clk);                                           // N+2 WAIT
        @(negedge clk); rst = 1'b1;                               // N+3
        tests++;
        if (st !== 6'b101000) begin
            fails++; $display("FAIL collision_wait got=%b exp=101000", st);
        end
        @(negedge clk); rst = 1'b0; wb_ack = 1'b1;                // N+4 late ack in IDLE
        tests++;
        if (st !== 6'b000000) begin
            fails++; $display("FAIL midwait_reset got=%b exp=000000", st);
        end
        @(negedge clk); wb_ack = 1'b0;                            // N+5
        tests++;
        if (st !== 6'b000000 || dm_data_l !== 32'h0) begin
            fails++; $display("FAIL reset_late_ack got st=%b dl=%h exp st=000000 dl=0", st, dm_data_l);
        end
        test_load(32'h603, 32'h55667788);
    endtask

    initial begin
        test_reset();
        test_load(32'h104, 32'h11223344);
        test_store();
        test_stall();
        test_timeout();
        test_store_err();
        test_collision_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
